// File: rtl/rect_loader.sv
`default_nettype none
// ============================================================================
// Module   : rect_loader
// Purpose  : Per-frame fetch stage of the GPU rectangle path. On a frame-start
//            pulse it walks the rectangle table in video memory, reads each
//            5-word record (x, y, width, height, colour), forms the right and
//            bottom edges, clamps all four edges to the 640x480 screen and
//            emits one registered descriptor per record.
// Revision : 1.0 - initial release
// ============================================================================
module rect_loader #(
    parameter int                    RECT_COUNT = 64,
    parameter int                    ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    output logic                  busy,
    output logic                  rect_valid,
    output logic [5:0]            rect_index,
    output logic [9:0]            rect_x0,
    output logic [9:0]            rect_x1,
    output logic [9:0]            rect_y0,
    output logic [9:0]            rect_y1,
    output logic [15:0]           rect_color,
    output logic                  rect_empty,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_TAIL  = 2'd2
    } state_t;

    localparam logic [5:0]            c_last_rec = 6'(RECT_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_busy;
    logic                  w_last;
    logic                  w_accept;

    logic [2:0]            r_word;
    logic [5:0]            r_rec;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_x;
    logic [15:0]           r_y;
    logic [15:0]           r_w;
    logic [15:0]           r_h;

    logic                  r_valid;
    logic                  r_done;
    logic [5:0]            r_index;
    logic [9:0]            r_x0;
    logic [9:0]            r_x1;
    logic [9:0]            r_y0;
    logic [9:0]            r_y1;
    logic [15:0]           r_color;
    logic                  r_empty;

    logic [15:0]           w_xe;
    logic [15:0]           w_ye;
    logic [9:0]            w_x0;
    logic [9:0]            w_x1;
    logic [9:0]            w_y0;
    logic [9:0]            w_y1;

    // Screen clamp stage: mode=1 clamps against the 640-pixel width,
    // mode=0 against the 480-line height. Negative edges pin to 0.
    function automatic logic [9:0] clamp_edge(input logic [15:0] v, input logic mode);
        logic [15:0] lim;
        lim = mode ? 16'd640 : 16'd480;
        if (v[15])
            return 10'd0;
        else if (v >= lim)
            return lim[9:0];
        else
            return v[9:0];
    endfunction

    // Edge arithmetic wraps in 16 bits; clamping happens afterwards
    assign w_xe = r_x + r_w;
    assign w_ye = r_y + r_h;
    assign w_x0 = clamp_edge(r_x,  1'b1);
    assign w_x1 = clamp_edge(w_xe, 1'b1);
    assign w_y0 = clamp_edge(r_y,  1'b0);
    assign w_y1 = clamp_edge(w_ye, 1'b0);

    assign w_last   = (r_rec == c_last_rec);
    // The done cycle is already IDLE but still counts as part of the walk
    assign w_accept = start && !r_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and busy decode
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_busy = 1'b1;
                if (r_word == 3'd4)
                    w_state_next = S_TAIL;
            end
            S_TAIL: begin
                w_busy       = 1'b1;
                w_state_next = w_last ? S_IDLE : S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address walk, word capture and descriptor registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word  <= 3'd0;
            r_rec   <= 6'd0;
            r_addr  <= BASE_ADDR;
            r_x     <= 16'd0;
            r_y     <= 16'd0;
            r_w     <= 16'd0;
            r_h     <= 16'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_index <= 6'd0;
            r_x0    <= 10'd0;
            r_x1    <= 10'd0;
            r_y0    <= 10'd0;
            r_y1    <= 10'd0;
            r_color <= 16'd0;
            r_empty <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= BASE_ADDR;
                        r_word <= 3'd0;
                        r_rec  <= 6'd0;
                    end
                end
                S_FETCH: begin
                    // Read data lags the address by one cycle, so word k-1
                    // is on mem_rdata while r_word is k
                    case (r_word)
                        3'd1:    r_x <= mem_rdata;
                        3'd2:    r_y <= mem_rdata;
                        3'd3:    r_w <= mem_rdata;
                        3'd4:    r_h <= mem_rdata;
                        default: ;
                    endcase
                    r_word <= r_word + 3'd1;
                    if (r_word != 3'd4)
                        r_addr <= r_addr + c_addr_one;
                end
                S_TAIL: begin
                    // Colour word is on mem_rdata now; publish the descriptor
                    r_valid <= 1'b1;
                    r_done  <= w_last;
                    r_index <= r_rec;
                    r_x0    <= w_x0;
                    r_x1    <= w_x1;
                    r_y0    <= w_y0;
                    r_y1    <= w_y1;
                    r_color <= mem_rdata;
                    r_empty <= (w_x1 <= w_x0) || (w_y1 <= w_y0);
                    if (!w_last) begin
                        r_rec  <= r_rec + 6'd1;
                        r_word <= 3'd0;
                        r_addr <= r_addr + c_addr_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign busy       = w_busy;
    assign rect_valid = r_valid;
    assign done       = r_done;
    assign rect_index = r_index;
    assign rect_x0    = r_x0;
    assign rect_x1    = r_x1;
    assign rect_y0    = r_y0;
    assign rect_y1    = r_y1;
    assign rect_color = r_color;
    assign rect_empty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_rect_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_loader
// Purpose  : Directed self-checking bench for rect_loader. Instance A walks a
//            single record at address 0, instance B walks four records at
//            0x100. A shared behavioural memory answers one cycle after the
//            address is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a;
    logic        start_b;
    logic [12:0] addr_a, addr_b;
    logic [15:0] rdata_a, rdata_b;

    logic        busy_a, valid_a, done_a, emp_a;
    logic [5:0]  idx_a;
    logic [9:0]  x0_a, x1_a, y0_a, y1_a;
    logic [15:0] col_a;

    logic        busy_b, valid_b, done_b, emp_b;
    logic [5:0]  idx_b;
    logic [9:0]  x0_b, x1_b, y0_b, y1_b;
    logic [15:0] col_b;

    logic [62:0] fields_a, fields_b;

    logic [15:0] mem [0:8191];

    int n_pass  = 0;
    int n_total = 0;

    // Hand-computed records and results for instance B
    logic [15:0] rx [4];
    logic [15:0] ry [4];
    logic [15:0] rw [4];
    logic [15:0] rh [4];
    logic [15:0] rc [4];
    logic [9:0]  ex0 [4];
    logic [9:0]  ex1 [4];
    logic [9:0]  ey0 [4];
    logic [9:0]  ey1 [4];
    logic        eemp [4];

    always #5 clk = ~clk;

    // Read data appears the cycle after the address
    always @(posedge clk) begin
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

    assign fields_a = {idx_a, x0_a, x1_a, y0_a, y1_a, col_a, emp_a};
    assign fields_b = {idx_b, x0_b, x1_b, y0_b, y1_b, col_b, emp_b};

    rect_loader #(.RECT_COUNT(1), .ADDR_WIDTH(13), .BASE_ADDR(13'h000)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .mem_addr(addr_a), .mem_rdata(rdata_a), .busy(busy_a),
        .rect_valid(valid_a), .rect_index(idx_a),
        .rect_x0(x0_a), .rect_x1(x1_a), .rect_y0(y0_a), .rect_y1(y1_a),
        .rect_color(col_a), .rect_empty(emp_a), .done(done_a)
    );

    rect_loader #(.RECT_COUNT(4), .ADDR_WIDTH(13), .BASE_ADDR(13'h100)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .mem_addr(addr_b), .mem_rdata(rdata_b), .busy(busy_b),
        .rect_valid(valid_b), .rect_index(idx_b),
        .rect_x0(x0_b), .rect_x1(x1_b), .rect_y0(y0_b), .rect_y1(y1_b),
        .rect_color(col_b), .rect_empty(emp_b), .done(done_b)
    );

    task automatic test_reset();
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy_a, valid_a, done_a, fields_a} !== 66'd0)
            $display("FAIL reset_a_outputs: got %h want 0", {busy_a, valid_a, done_a, fields_a});
        else n_pass++;
        n_total++;
        if (addr_a !== 13'h000)
            $display("FAIL reset_a_addr: got %h want 000", addr_a);
        else n_pass++;
        n_total++;
        if ({busy_b, valid_b, done_b, fields_b} !== 66'd0)
            $display("FAIL reset_b_outputs: got %h want 0", {busy_b, valid_b, done_b, fields_b});
        else n_pass++;
        n_total++;
        if (addr_b !== 13'h100)
            $display("FAIL reset_b_addr: got %h want 100", addr_b);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One full walk of instance A with one record at address 0
    task automatic run_one_record(input string tag,
                                  input logic [15:0] x, input logic [15:0] y,
                                  input logic [15:0] w, input logic [15:0] h,
                                  input logic [15:0] col,
                                  input logic [9:0] e_x0, input logic [9:0] e_x1,
                                  input logic [9:0] e_y0, input logic [9:0] e_y1,
                                  input logic e_emp);
        logic [62:0] e_fields;
        logic [2:0]  exp_ctl;
        logic [12:0] exp_addr;
        e_fields = {6'd0, e_x0, e_x1, e_y0, e_y1, col, e_emp};
        mem[0] = x;
        mem[1] = y;
        mem[2] = w;
        mem[3] = h;
        mem[4] = col;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) @(negedge clk);
            exp_ctl = {(c < 6), (c == 6), (c == 6)};
            n_total++;
            if ({busy_a, valid_a, done_a} !== exp_ctl)
                $display("FAIL %s busy/valid/done cycle %0d: got %b want %b",
                         tag, c, {busy_a, valid_a, done_a}, exp_ctl);
            else n_pass++;
            if (c < 6) begin
                exp_addr = (c < 5) ? 13'(c) : 13'd4;
                n_total++;
                if (addr_a !== exp_addr)
                    $display("FAIL %s addr cycle %0d: got %h want %h", tag, c, addr_a, exp_addr);
                else n_pass++;
            end else begin
                n_total++;
                if (fields_a !== e_fields)
                    $display("FAIL %s descriptor cycle %0d: got %h want %h", tag, c, fields_a, e_fields);
                else n_pass++;
            end
        end
    endtask

    task automatic test_single();
        run_one_record("single", 16'd100, 16'd50, 16'd20, 16'd10, 16'hF800,
                       10'd100, 10'd120, 10'd50, 10'd60, 1'b0);
    endtask

    task automatic test_clamp();
        run_one_record("clamp_neg_bottom", 16'hFFE2, 16'd470, 16'd50, 16'd30, 16'h07E0,
                       10'd0, 10'd20, 10'd470, 10'd480, 1'b0);
        run_one_record("clamp_right_wrap", 16'd630, 16'hFFFF, 16'd40, 16'hFFFF, 16'h001F,
                       10'd630, 10'd640, 10'd0, 10'd0, 1'b1);
    endtask

    task automatic test_empty();
        run_one_record("empty_zero_w", 16'd200, 16'd10, 16'd0, 16'd10, 16'h1234,
                       10'd200, 10'd200, 10'd10, 10'd20, 1'b1);
        run_one_record("empty_left", 16'hFFFB, 16'd0, 16'd3, 16'd1, 16'h5555,
                       10'd0, 10'd0, 10'd0, 10'd1, 1'b1);
        run_one_record("empty_right", 16'd700, 16'd10, 16'd5, 16'd5, 16'hAAAA,
                       10'd640, 10'd640, 10'd10, 10'd15, 1'b1);
    endtask

    // Four-record walk with ignored starts at cycles 3 and 24, restart at 25
    task automatic test_sequence_and_start();
        int          r, k, ea;
        logic [2:0]  exp_ctl;
        logic [62:0] e_fields;
        for (int i = 0; i < 4; i++) begin
            mem[13'h100 + 5*i + 0] = rx[i];
            mem[13'h100 + 5*i + 1] = ry[i];
            mem[13'h100 + 5*i + 2] = rw[i];
            mem[13'h100 + 5*i + 3] = rh[i];
            mem[13'h100 + 5*i + 4] = rc[i];
        end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 24) begin
                r  = c / 6;
                k  = c % 6;
                ea = 32'h100 + 5*r + ((k < 5) ? k : 4);
            end else begin
                ea = 32'h113;
            end
            exp_ctl = {(c < 24), (c > 0 && c % 6 == 0 && c <= 24), (c == 24)};
            n_total++;
            if ({busy_b, valid_b, done_b} !== exp_ctl)
                $display("FAIL seq busy/valid/done cycle %0d: got %b want %b",
                         c, {busy_b, valid_b, done_b}, exp_ctl);
            else n_pass++;
            n_total++;
            if (addr_b !== 13'(ea))
                $display("FAIL seq addr cycle %0d: got %h want %h", c, addr_b, 13'(ea));
            else n_pass++;
            if (exp_ctl[1]) begin
                r = c / 6 - 1;
                e_fields = {6'(r), ex0[r], ex1[r], ey0[r], ey1[r], rc[r], eemp[r]};
                n_total++;
                if (fields_b !== e_fields)
                    $display("FAIL seq descriptor %0d: got %h want %h", r, fields_b, e_fields);
                else n_pass++;
            end
            start_b = (c == 3 || c == 24 || c == 25);
        end
        // Restart accepted: first cycle of the new walk
        @(negedge clk);
        start_b = 1'b0;
        n_total++;
        if ({busy_b, addr_b} !== {1'b1, 13'h100})
            $display("FAIL restart busy/addr: got %b/%h want 1/100", busy_b, addr_b);
        else n_pass++;
    endtask

    // Continues the walk begun at the end of test_sequence_and_start
    task automatic test_reset_midwalk();
        logic [62:0] e_fields;
        int          saw_activity;
        e_fields = {6'd0, ex0[0], ex1[0], ey0[0], ey1[0], rc[0], eemp[0]};
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 6) begin
                n_total++;
                if ({valid_b, fields_b} !== {1'b1, e_fields})
                    $display("FAIL midwalk rec0: got %h want %h", {valid_b, fields_b}, {1'b1, e_fields});
                else n_pass++;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if ({busy_b, valid_b, done_b, fields_b} !== 66'd0)
            $display("FAIL midwalk reset outputs: got %h want 0", {busy_b, valid_b, done_b, fields_b});
        else n_pass++;
        n_total++;
        if (addr_b !== 13'h100)
            $display("FAIL midwalk reset addr: got %h want 100", addr_b);
        else n_pass++;
        saw_activity = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy_b || done_b || valid_b) saw_activity++;
        end
        n_total++;
        if (saw_activity !== 0)
            $display("FAIL midwalk idle after reset: got %0d active cycles want 0", saw_activity);
        else n_pass++;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n_total++;
        if ({busy_b, addr_b} !== {1'b1, 13'h100})
            $display("FAIL midwalk restart busy/addr: got %b/%h want 1/100", busy_b, addr_b);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_total++;
        if ({valid_b, done_b, fields_b} !== {1'b1, 1'b0, e_fields})
            $display("FAIL midwalk restart rec0: got %h want %h",
                     {valid_b, done_b, fields_b}, {1'b1, 1'b0, e_fields});
        else n_pass++;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rx   = '{16'd100, 16'hFFE2, 16'd630, 16'd700};
        ry   = '{16'd50, 16'd470, 16'hFFFF, 16'd10};
        rw   = '{16'd20, 16'd50, 16'd40, 16'd5};
        rh   = '{16'd10, 16'd30, 16'hFFFF, 16'd5};
        rc   = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        ex0  = '{10'd100, 10'd0, 10'd630, 10'd640};
        ex1  = '{10'd120, 10'd20, 10'd640, 10'd640};
        ey0  = '{10'd50, 10'd470, 10'd0, 10'd10};
        ey1  = '{10'd60, 10'd480, 10'd0, 10'd15};
        eemp = '{1'b0, 1'b0, 1'b1, 1'b1};

        test_reset();
        test_single();
        test_clamp();
        test_empty();
        test_sequence_and_start();
        test_reset_midwalk();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rect_loader.md
Name: rect_loader

Overview:
- Per-frame fetch stage of the GPU rectangle path.
- On a frame-start pulse it walks the rectangle table in video memory and reads each 5-word record.
- For each record it forms right and bottom edges, then clamps all four edges to the 640x480 screen using the existing clamp stage: mode=1 for X, mode=0 for Y.
- It emits one registered rectangle descriptor per record to the downstream rectangle buffer.

Parameters:
- RECT_COUNT, 64, number of records walked per frame (1..64).
- BASE_ADDR, 13'd0, word address of record 0.
- ADDR_WIDTH, 13, width of mem_addr.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  frame-start pulse (vsync); sampled only in IDLE
- mem_addr  out  ADDR_WIDTH  video memory read address
- mem_rdata  in  16  read data; valid the cycle after its address is presented
- busy  out  1  high while walking the table
- rect_valid  out  1  one-cycle strobe: descriptor outputs are valid
- rect_index  out  6  record number of the current descriptor
- rect_x0, rect_x1  out  10  clamped left/right edge (right exclusive)
- rect_y0, rect_y1  out  10  clamped top/bottom edge (bottom exclusive)
- rect_color  out  16  colour word, passed through unchanged
- rect_empty  out  1  clamped x1<=x0 or y1<=y0
- done  out  1  one-cycle strobe with the last descriptor

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Record layout, 5 consecutive words: +0 x (signed 16), +1 y (signed 16), +2 width (unsigned 16), +3 height (unsigned 16), +4 colour. Record r base = BASE_ADDR + 5r.
- Reset values:
  - state IDLE; mem_addr = BASE_ADDR.
  - busy, rect_valid, done, rect_empty = 0.
  - rect_index, rect_x0/x1/y0/y1, rect_color = 0.
- States:
  - IDLE: start=1 -> FETCH, word=0, rec=0, mem_addr=BASE_ADDR.
  - FETCH: word 0..4, mem_addr = record base + word, word increments each cycle. After word 4 -> TAIL.
  - TAIL: capture word 4 and register the descriptor. If rec = RECT_COUNT-1 -> IDLE. Otherwise -> FETCH with rec+1, word=0.
- Timing, with cycle 0 the first cycle after start is sampled:
  - Record r addresses are presented in cycles 6r..6r+4.
  - Data for word k is captured in cycle 6r+k+1.
  - rect_valid is high in cycle 6r+6 only.
  - busy is high in cycles 0..6*RECT_COUNT-1.
  - done is high in cycle 6*RECT_COUNT, coincident with the last rect_valid.
- Arithmetic:
  - xe = x + width, ye = y + height: 16-bit, two's-complement wraparound, no saturation.
  - Clamp rule, applied per edge: negative -> 0; >= limit (640 for X, 480 for Y) -> limit; else low 10 bits.
  - x0 = clamp(x), x1 = clamp(xe), y0 = clamp(y), y1 = clamp(ye).
- rect_empty is computed from the clamped values (unsigned compare). rect_valid is still pulsed for empty rectangles; the consumer discards them.
- Descriptor outputs hold their value between strobes and change only in the cycle rect_valid rises.
- start while busy (including the done cycle) is ignored. start in the cycle after done begins a new walk.
- reset mid-walk: return to IDLE next cycle, all outputs to reset values, no done.
- mem_addr in TAIL and IDLE holds its last value. The memory read is unconditional; there is no enable.

Test Plan:
- Single record, RECT_COUNT=1, x=100 y=50 w=20 h=10 colour=0xF800 -> cycle 6: rect_valid=1, done=1, index=0, x0=100 x1=120 y0=50 y1=60, colour=0xF800, empty=0; busy high cycles 0..5.
- Negative/overflow clamp, x=-30 w=50 y=470 h=30 -> x0=0 x1=20 y0=470 y1=480. Then x=630 w=40 y=-1 h=0xFFFF -> x0=630 x1=640 y0=0 y1=0, empty=1.
- Empty cases:
  - w=0 at x=200 -> x0=x1=200, empty=1.
  - x=-5 w=3 -> x0=x1=0, empty=1.
  - x=700 w=5 -> x0=x1=640, empty=1.
- Address and strobe sequencing, RECT_COUNT=4, BASE_ADDR=0x100 -> mem_addr 0x100..0x104, 0x105..0x109, ...; rect_valid at cycles 6,12,18,24 with index 0..3; done only at 24.
- start re-asserted at cycles 3 and 24 of a walk -> both ignored, no restart. start at cycle 25 -> new walk, mem_addr=BASE_ADDR at cycle 26.
- reset at cycle 9 of a RECT_COUNT=4 walk -> cycle 10: busy=0, rect_valid=0, all descriptor outputs 0, no done. A later start restarts from record 0.
